// File: rtl/pwm_compare_4bit.sv
// pwm_compare_4bit: double-buffered duty PWM driven by an upstream 4-bit counter,
// with period-start strobe and sticky count-sequence error flag.
module pwm_compare_4bit #(
   parameter int DUTY_RESET = 8,
   parameter int CHECK_SEQ  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] cnt_in,
   input  logic [4:0] duty_in,
   input  logic       duty_valid,
   output logic       duty_ready,
   output logic       pwm_out,
   output logic       period_start,
   output logic       seq_err
);
   logic [4:0] duty_active, duty_pending, duty_sat, eff_duty;
   logic [3:0] prev_cnt;
   logic       pending_full, have_prev, boundary, swap, accept, bad_seq;

   assign duty_ready = !pending_full;

   // A value accepted on the boundary cycle only lands in pending; the swap
   // consumes what was already there.
   always_comb begin
      boundary = cnt_in == 4'd0;
      swap     = boundary && pending_full;
      accept   = duty_valid && !pending_full;
      duty_sat = duty_in > 5'd16 ? 5'd16 : duty_in;
      eff_duty = swap ? duty_pending : duty_active;
      bad_seq  = (CHECK_SEQ != 0) && have_prev && (cnt_in != prev_cnt + 4'd1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
         seq_err      <= 1'b0;
         duty_active  <= 5'(DUTY_RESET);
         duty_pending <= 5'd0;
         pending_full <= 1'b0;
         prev_cnt     <= 4'd0;
         have_prev    <= 1'b0;
      end else begin
         pwm_out      <= {1'b0, cnt_in} < eff_duty;
         period_start <= boundary;
         prev_cnt     <= cnt_in;
         have_prev    <= 1'b1;
         if (bad_seq) seq_err <= 1'b1;
         if (swap) begin
            duty_active  <= duty_pending;
            pending_full <= 1'b0;
         end
         if (accept) begin
            duty_pending <= duty_sat;
            pending_full <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_pwm_compare_4bit.sv
// tb_pwm_compare_4bit: directed periods with hand-stated duties; expected
// outputs are queued per cycle and checked by an independent monitor.
module tb_pwm_compare_4bit;
   typedef struct {
      int   cyc;
      logic pwm;
      logic ps;
      logic err;
      logic rdy;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] cnt_in = 4'd0;
   logic [4:0] duty_in = 5'd0;
   logic       duty_valid = 1'b0;
   logic       duty_ready, pwm_out, period_start, seq_err;
   logic       duty_ready_n, pwm_out_n, period_start_n, seq_err_n;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   logic err_exp = 1'b0;

   always #5 clk = ~clk;

   pwm_compare_4bit #(.DUTY_RESET(8), .CHECK_SEQ(1)) dut (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .duty_in(duty_in), .duty_valid(duty_valid),
      .duty_ready(duty_ready), .pwm_out(pwm_out), .period_start(period_start), .seq_err(seq_err)
   );

   pwm_compare_4bit #(.DUTY_RESET(8), .CHECK_SEQ(0)) dut_nochk (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .duty_in(duty_in), .duty_valid(duty_valid),
      .duty_ready(duty_ready_n), .pwm_out(pwm_out_n), .period_start(period_start_n), .seq_err(seq_err_n)
   );

   task automatic chk(input string name, input int c, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%b want=%b", name, c, got, want);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("pwm_out", mon_e.cyc, pwm_out, mon_e.pwm);
         chk("period_start", mon_e.cyc, period_start, mon_e.ps);
         chk("seq_err", mon_e.cyc, seq_err, mon_e.err);
         chk("duty_ready", mon_e.cyc, duty_ready, mon_e.rdy);
         chk("nochk_pwm_out", mon_e.cyc, pwm_out_n, mon_e.pwm);
         chk("nochk_seq_err", mon_e.cyc, seq_err_n, 1'b0);
      end
   end

   task automatic step(input logic [3:0] c, input logic v, input logic [4:0] d, input logic r,
                       input logic ep, input logic es, input logic ee, input logic er);
      @(negedge clk);
      cnt_in = c;
      duty_valid = v;
      duty_in = d;
      rst = r;
      exp_q.push_back('{cyc, ep, es, ee, er});
      cyc++;
   endtask

   // One period (or its first n counts) at a known duty, with up to two valid
   // windows and the window where duty_ready is expected low.
   task automatic period(input int duty, input int n,
                         input int af, input int at, input logic [4:0] av,
                         input int bf, input int bt, input logic [4:0] bv,
                         input int lf, input int lt);
      logic ina, inb;
      for (int c = 0; c < n; c++) begin
         ina = c >= af && c <= at;
         inb = c >= bf && c <= bt;
         step(4'(c), ina || inb, ina ? av : (inb ? bv : 5'd0), 1'b0,
              c < duty, c == 0, err_exp, !(c >= lf && c <= lt));
      end
   endtask

   initial begin
      int c;
      step(4'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(4'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      period(8, 16, 99, -1, 5'd0, 99, -1, 5'd0, 99, -1);
      period(8, 16, 5, 5, 5'd3, 99, -1, 5'd0, 5, 15);
      period(3, 16, 5, 5, 5'd0, 99, -1, 5'd0, 5, 15);
      period(0, 16, 5, 5, 5'd16, 99, -1, 5'd0, 5, 15);
      period(16, 16, 5, 5, 5'd20, 99, -1, 5'd0, 5, 15);
      period(16, 16, 5, 5, 5'd3, 6, 15, 5'd5, 5, 15);
      period(3, 16, 0, 1, 5'd5, 99, -1, 5'd0, 1, 15);
      period(5, 16, 99, -1, 5'd0, 99, -1, 5'd0, 99, -1);
      for (int k = 0; k < 14; k++) begin
         c = k < 7 ? k : k + 2;
         if (c == 9) err_exp = 1'b1;
         step(4'(c), 1'b0, 5'd0, 1'b0, c < 5, c == 0, err_exp, 1'b1);
      end
      period(5, 16, 99, -1, 5'd0, 99, -1, 5'd0, 99, -1);
      period(5, 8, 2, 2, 5'd12, 99, -1, 5'd0, 2, 7);
      err_exp = 1'b0;
      step(4'd8, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      period(8, 16, 99, -1, 5'd0, 99, -1, 5'd0, 99, -1);
      period(8, 16, 99, -1, 5'd0, 99, -1, 5'd0, 99, -1);
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
